// File: rtl/pulse_analyzer_if.sv
// pulse_analyzer_if: loop-back measurement bundle.
// master drives arm_i/pulse_i and reads the results.
// slave (the analyzer) drives the measured fields,
// busy_o and the one-cycle valid_o strobe.
interface pulse_analyzer_if;
   logic        arm_i;
   logic        pulse_i;
   logic [15:0] delay_o;
   logic [7:0]  width_o;
   logic [7:0]  num_pulses_o;
   logic [15:0] pulse_spacing_o;
   logic        overflow_o;
   logic        busy_o;
   logic        valid_o;

   modport master (
      output arm_i,
      output pulse_i,
      input  delay_o,
      input  width_o,
      input  num_pulses_o,
      input  pulse_spacing_o,
      input  overflow_o,
      input  busy_o,
      input  valid_o
   );

   modport slave (
      input  arm_i,
      input  pulse_i,
      output delay_o,
      output width_o,
      output num_pulses_o,
      output pulse_spacing_o,
      output overflow_o,
      output busy_o,
      output valid_o
   );
endinterface

// File: rtl/pulse_analyzer.sv
// pulse_analyzer: measures delay, first width, count and first
// spacing of a pulse train sampled on clk after an arm strobe.
// Ports: clk, rst (async, active-high), bus (slave modport):
//   arm_i/pulse_i in; delay/width/num_pulses/spacing,
//   overflow, busy and the one-cycle valid strobe out.
module pulse_analyzer #(
   parameter logic [15:0] IDLE_GAP = 16'd65535
) (
   input logic             clk,
   input logic             rst,
   pulse_analyzer_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_HIGH,
      ST_LOW
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] delay_q, delay_d;
   logic [7:0]  width_q, width_d;
   logic [7:0]  num_q, num_d;
   logic [15:0] spacing_q, spacing_d;
   logic [15:0] run_q, run_d;
   logic        ovf_q, ovf_d;
   logic        busy_q, busy_d;
   logic        valid_q, valid_d;
   logic        first_pulse;

   function automatic logic [15:0] inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Width and gap-1 spacing only track while exactly one
   // pulse has been counted; the count never decreases.
   assign first_pulse = (num_q == 8'd1);

   always_comb begin
      state_d   = state_q;
      delay_d   = delay_q;
      width_d   = width_q;
      num_d     = num_q;
      spacing_d = spacing_q;
      run_d     = run_q;
      ovf_d     = ovf_q;
      valid_d   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // pulse_i on the arm edge is deliberately ignored
            if (bus.arm_i) begin
               state_d   = ST_WAIT;
               delay_d   = 16'd0;
               width_d   = 8'd0;
               num_d     = 8'd0;
               spacing_d = 16'd0;
               run_d     = 16'd0;
               ovf_d     = 1'b0;
            end
         end

         ST_WAIT: begin
            if (bus.pulse_i) begin
               num_d   = 8'd1;
               width_d = 8'd1;
               run_d   = 16'd1;
               state_d = ST_HIGH;
            end else begin
               delay_d = inc16(delay_q);
               // no pulse within the delay range: timeout
               if (delay_d == 16'hFFFF) begin
                  ovf_d   = 1'b1;
                  state_d = ST_IDLE;
                  valid_d = 1'b1;
               end
            end
         end

         ST_HIGH: begin
            if (bus.pulse_i) begin
               run_d = inc16(run_q);
               if (first_pulse) begin
                  if (width_q == 8'hFF) begin
                     ovf_d = 1'b1;
                  end else begin
                     width_d = width_q + 8'd1;
                  end
               end
               // stuck high: abandon with overflow
               if (run_d == IDLE_GAP) begin
                  ovf_d   = 1'b1;
                  state_d = ST_IDLE;
                  valid_d = 1'b1;
               end
            end else begin
               run_d   = 16'd1;
               state_d = ST_LOW;
               if (first_pulse) begin
                  spacing_d = 16'd1;
               end
            end
         end

         ST_LOW: begin
            if (!bus.pulse_i) begin
               run_d = inc16(run_q);
               if (first_pulse) begin
                  spacing_d = inc16(spacing_q);
               end
               // long enough idle: train is over
               if (run_d == IDLE_GAP) begin
                  state_d = ST_IDLE;
                  valid_d = 1'b1;
                  if (first_pulse) begin
                     spacing_d = 16'd0;
                  end
               end
            end else begin
               if (num_q == 8'hFF) begin
                  ovf_d = 1'b1;
               end else begin
                  num_d = num_q + 8'd1;
               end
               run_d   = 16'd1;
               state_d = ST_HIGH;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         delay_q   <= 16'd0;
         width_q   <= 8'd0;
         num_q     <= 8'd0;
         spacing_q <= 16'd0;
         run_q     <= 16'd0;
         ovf_q     <= 1'b0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         delay_q   <= delay_d;
         width_q   <= width_d;
         num_q     <= num_d;
         spacing_q <= spacing_d;
         run_q     <= run_d;
         ovf_q     <= ovf_d;
         busy_q    <= busy_d;
         valid_q   <= valid_d;
      end
   end

   assign bus.delay_o         = delay_q;
   assign bus.width_o         = width_q;
   assign bus.num_pulses_o    = num_q;
   assign bus.pulse_spacing_o = spacing_q;
   assign bus.overflow_o      = ovf_q;
   assign bus.busy_o          = busy_q;
   assign bus.valid_o         = valid_q;

endmodule

// File: tb/tb_pulse_analyzer.sv
// tb_pulse_analyzer: table-driven pulse trains plus
// re-arm and reset corner sequences on two gap settings.
module tb_pulse_analyzer;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   pulse_analyzer_if if64 ();
   pulse_analyzer_if if1k ();

   pulse_analyzer #(.IDLE_GAP(16'd64)) u_dut64 (
      .clk (clk),
      .rst (rst),
      .bus (if64.slave)
   );

   pulse_analyzer #(.IDLE_GAP(16'd1024)) u_dut1k (
      .clk (clk),
      .rst (rst),
      .bus (if1k.slave)
   );

   typedef struct {
      int sel;
      int d;
      int w1;
      int w;
      int g;
      int n;
      int e_delay;
      int e_width;
      int e_num;
      int e_sp;
      int e_ovf;
      int e_lat;
   } vec_t;

   localparam int F_DELAY = 0;
   localparam int F_WIDTH = 1;
   localparam int F_NUM   = 2;
   localparam int F_SP    = 3;
   localparam int F_OVF   = 4;
   localparam int F_BUSY  = 5;
   localparam int F_VALID = 6;

   vec_t tbl [10];
   int   n_vec = 0;
   int   n_bad = 0;

   int rs_p [14] = '{0,0,0,0,1,1,1,0,0,0,0,0,1,1};
   int rs_a [14] = '{0,0,0,0,0,0,1,0,1,0,0,0,0,0};

   task automatic chk(input string nm, input int act,
                      input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   task automatic step(input logic a, input logic p);
      if64.arm_i   = a;
      if64.pulse_i = p;
      if1k.arm_i   = a;
      if1k.pulse_i = p;
      @(posedge clk);
      #1;
   endtask

   function automatic int rd(input int sel, input int f);
      int r;
      r = 0;
      case (f)
         F_DELAY: r = sel != 0 ? int'(if1k.delay_o)
                               : int'(if64.delay_o);
         F_WIDTH: r = sel != 0 ? int'(if1k.width_o)
                               : int'(if64.width_o);
         F_NUM:   r = sel != 0 ? int'(if1k.num_pulses_o)
                               : int'(if64.num_pulses_o);
         F_SP:    r = sel != 0 ? int'(if1k.pulse_spacing_o)
                               : int'(if64.pulse_spacing_o);
         F_OVF:   r = sel != 0 ? int'(if1k.overflow_o)
                               : int'(if64.overflow_o);
         F_BUSY:  r = sel != 0 ? int'(if1k.busy_o)
                               : int'(if64.busy_o);
         F_VALID: r = sel != 0 ? int'(if1k.valid_o)
                               : int'(if64.valid_o);
         default: r = 0;
      endcase
      return r;
   endfunction

   // Sample i after the arm edge of the described train.
   function automatic logic pulse_at(input vec_t v, input int i);
      logic r;
      bit   fin;
      int   j;
      int   hi;
      r   = 1'b0;
      fin = 1'b0;
      if (i >= v.d) begin
         j = i - v.d;
         for (int p = 0; p < v.n; p++) begin
            if (!fin) begin
               hi = (p == 0) ? v.w1 : v.w;
               if (j < hi) begin
                  r   = 1'b1;
                  fin = 1'b1;
               end else begin
                  j -= hi;
                  if (p == v.n - 1 || j < v.g) begin
                     fin = 1'b1;
                  end else begin
                     j -= v.g;
                  end
               end
            end
         end
      end
      return r;
   endfunction

   task automatic wait_idle();
      int k;
      k = 0;
      while ((if64.busy_o || if1k.busy_o) && k < 3000) begin
         step(1'b0, 1'b0);
         k++;
      end
      chk("idle_wait", int'(if64.busy_o | if1k.busy_o), 0);
   endtask

   task automatic check_res(input int sel, input int dl,
                            input int wd, input int nm,
                            input int sp, input int ov);
      chk("delay", rd(sel, F_DELAY), dl);
      chk("width", rd(sel, F_WIDTH), wd);
      chk("num_pulses", rd(sel, F_NUM), nm);
      chk("spacing", rd(sel, F_SP), sp);
      chk("overflow", rd(sel, F_OVF), ov);
   endtask

   // Drive low until the selected unit leaves busy.
   task automatic finish_low(input int sel, input int budget,
                             output int lows);
      int k;
      k = 0;
      while (rd(sel, F_BUSY) != 0 && k < budget) begin
         step(1'b0, 1'b0);
         k++;
      end
      lows = k;
      chk("end_seen", rd(sel, F_BUSY), 0);
      chk("valid_at_end", rd(sel, F_VALID), 1);
   endtask

   task automatic run_vec(input vec_t v);
      int   i;
      int   lows;
      bit   done;
      logic p;
      wait_idle();
      step(1'b1, 1'b0);
      chk("busy_after_arm", rd(v.sel, F_BUSY), 1);
      i    = 0;
      lows = 0;
      done = 1'b0;
      while (!done && i < 6000) begin
         p = pulse_at(v, i);
         step(1'b0, p);
         lows = p ? 0 : lows + 1;
         if (rd(v.sel, F_BUSY) == 0) done = 1'b1;
         i++;
      end
      chk("end_seen", int'(done), 1);
      chk("valid_at_end", rd(v.sel, F_VALID), 1);
      if (v.e_lat != 0) chk("end_latency", lows, v.e_lat);
      check_res(v.sel, v.e_delay, v.e_width, v.e_num,
                v.e_sp, v.e_ovf);
      step(1'b0, 1'b0);
      chk("valid_one_cycle", rd(v.sel, F_VALID), 0);
      chk("hold_delay", rd(v.sel, F_DELAY), v.e_delay);
   endtask

   initial begin
      int   cnt;
      int   lows;
      int   nvalid;
      vec_t v;

      tbl[0] = '{0, 10,   4, 4,  6,   3, 10,   4,   3,  6, 0,   64};
      tbl[1] = '{0,  0,   1, 1,  0,   1,  0,   1,   1,  0, 0,   64};
      tbl[2] = '{0,  5,   2, 2,  1,   2,  5,   2,   2,  1, 0,   64};
      tbl[3] = '{0,  3,   7, 7, 63,   2,  3,   7,   2, 63, 0,   64};
      tbl[4] = '{0,  1,  63, 3,  3,   4,  1,  63,   4,  3, 0,   64};
      tbl[5] = '{0,  2,  64, 1,  1,   1,  2,  64,   1,  0, 1,    0};
      tbl[6] = '{0,  7,   5, 1,  2,   5,  7,   5,   5,  2, 0,   64};
      tbl[7] = '{0,  0,   2, 2, 64,   2,  0,   2,   1,  0, 0,   64};
      tbl[8] = '{1, 10,   4, 4,  6,   3, 10,   4,   3,  6, 0, 1024};
      tbl[9] = '{1,  0, 300, 2,  2, 260,  0, 255, 255,  2, 1, 1024};

      rst = 1'b1;
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      check_res(0, 0, 0, 0, 0, 0);
      chk("reset_busy", rd(0, F_BUSY), 0);
      chk("reset_valid", rd(0, F_VALID), 0);
      rst = 1'b0;
      step(1'b0, 1'b0);

      for (int t = 0; t < 10; t++) begin
         run_vec(tbl[t]);
      end

      // No pulse at all: delay counter times out.
      wait_idle();
      step(1'b1, 1'b0);
      cnt = 0;
      while (if64.busy_o && cnt < 70000) begin
         step(1'b0, 1'b0);
         cnt++;
      end
      chk("timeout_samples", cnt, 65535);
      chk("timeout_valid", rd(0, F_VALID), 1);
      check_res(0, 65535, 0, 0, 0, 1);

      // Arm strobes inside a pulse and inside a gap.
      wait_idle();
      step(1'b1, 1'b0);
      for (int i = 0; i < 14; i++) begin
         step(rs_a[i] != 0, rs_p[i] != 0);
      end
      finish_low(0, 200, lows);
      check_res(0, 4, 3, 2, 5, 0);

      // Arm in the valid cycle is accepted and clears results.
      step(1'b1, 1'b0);
      chk("rearm_busy", rd(0, F_BUSY), 1);
      chk("rearm_valid", rd(0, F_VALID), 0);
      check_res(0, 0, 0, 0, 0, 0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      finish_low(0, 200, lows);
      chk("rearm_latency", lows, 64);
      check_res(0, 0, 2, 1, 0, 0);

      // Reset while inside a pulse.
      wait_idle();
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      chk("pre_rst_busy", rd(0, F_BUSY), 1);
      chk("pre_rst_width", rd(0, F_WIDTH), 3);
      #2;
      rst = 1'b1;
      #1;
      check_res(0, 0, 0, 0, 0, 0);
      chk("rst_busy", rd(0, F_BUSY), 0);
      chk("rst_valid", rd(0, F_VALID), 0);
      #1;
      rst = 1'b0;
      nvalid = 0;
      for (int i = 0; i < 100; i++) begin
         step(1'b0, 1'b0);
         nvalid += rd(0, F_VALID);
      end
      chk("no_valid_after_rst", nvalid, 0);
      v = '{0, 3, 2, 2, 4, 2, 3, 2, 2, 4, 0, 64};
      run_vec(v);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
